// File: rtl/strcmp_core.sv
// strcmp_core: two word FIFOs (string A / string B) feeding a byte-serial
// C-strcmp comparator. Optional ASCII case folding is compiled in when the
// macro STRCMP_CASE_FOLD_EN is defined; the default build compares raw bytes.
module strcmp_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        fifo_write,
    input  logic        fifo_select,
    input  logic        go,
    input  logic        clear,
    output logic [31:0] result,
    output logic [15:0] match_index,
    output logic        done,
    output logic        busy,
    output logic        fifo_a_full,
    output logic        fifo_b_full,
    output logic        overflow
);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = PTR_W + 3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(4 * FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Select byte lane 'sel' of a packed word; lane 0 is the first character.
    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

`ifdef STRCMP_CASE_FOLD_EN
    // Map 'A'..'Z' onto 'a'..'z'; every other byte passes through.
    function automatic logic [7:0] fold_byte(input logic [7:0] b);
        logic [7:0] f;
        if ((b >= 8'h41) && (b <= 8'h5A)) begin
            f = b + 8'h20;
        end else begin
            f = b;
        end
        return f;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               decided_q, decided_d;
    logic [31:0]        result_q, result_d;
    logic [IDX_W-1:0]   match_q, match_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        mem_a_q [FIFO_DEPTH];
    logic [31:0]        mem_b_q [FIFO_DEPTH];

    logic [PTR_W-1:0]   word_sel_s;
    logic               in_range_s;
    logic [7:0]         a_raw_s, b_raw_s, a_cmp_s, b_cmp_s;
    logic [8:0]         diff_s;
    logic               wr_ok_s, wr_a_s, wr_b_s, wr_drop_s;

    // Fetch byte i of each string; bytes past the written words read as NUL.
    always_comb begin
        word_sel_s = idx_q[PTR_W+1:2];
        in_range_s = (idx_q < IDX_END);
        if (in_range_s && ({1'b0, word_sel_s} < cnt_a_q)) begin
            a_raw_s = pick_byte(mem_a_q[word_sel_s], idx_q[1:0]);
        end else begin
            a_raw_s = 8'h00;
        end
        if (in_range_s && ({1'b0, word_sel_s} < cnt_b_q)) begin
            b_raw_s = pick_byte(mem_b_q[word_sel_s], idx_q[1:0]);
        end else begin
            b_raw_s = 8'h00;
        end
`ifdef STRCMP_CASE_FOLD_EN
        a_cmp_s = fold_byte(a_raw_s);
        b_cmp_s = fold_byte(b_raw_s);
`else
        a_cmp_s = a_raw_s;
        b_cmp_s = b_raw_s;
`endif
        diff_s = {1'b0, a_cmp_s} - {1'b0, b_cmp_s};
    end

    // Write acceptance: only in IDLE, only into a non-full FIFO; clear wins.
    always_comb begin
        wr_ok_s   = fifo_write && !clear && (state_q == ST_IDLE);
        wr_a_s    = wr_ok_s && !fifo_select && (cnt_a_q != CNT_FULL);
        wr_b_s    = wr_ok_s &&  fifo_select && (cnt_b_q != CNT_FULL);
        wr_drop_s = fifo_write && !clear && !(wr_a_s || wr_b_s);
    end

    // Next-state logic for the control FSM, counters and result registers.
    always_comb begin
        state_d    = state_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        idx_d      = idx_q;
        decided_d  = decided_q;
        result_d   = result_q;
        match_d    = match_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = ST_IDLE;
            cnt_a_d    = {CNT_W{1'b0}};
            cnt_b_d    = {CNT_W{1'b0}};
            decided_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            cnt_a_d    = wr_a_s ? (cnt_a_q + CNT_W'(1)) : cnt_a_q;
            cnt_b_d    = wr_b_s ? (cnt_b_q + CNT_W'(1)) : cnt_b_q;
            overflow_d = overflow_q | wr_drop_s;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_d   = ST_COMPARE;
                        idx_d     = {IDX_W{1'b0}};
                        decided_d = 1'b0;
                    end else begin
                        state_d   = state_q;
                    end
                end
                ST_COMPARE: begin
                    // The decision is registered one cycle before DONE is entered.
                    if (decided_q) begin
                        state_d = ST_DONE;
                    end else if (!in_range_s) begin
                        result_d  = 32'h0000_0000;
                        match_d   = IDX_END;
                        decided_d = 1'b1;
                    end else if (a_cmp_s != b_cmp_s) begin
                        result_d  = {{23{diff_s[8]}}, diff_s};
                        match_d   = idx_q;
                        decided_d = 1'b1;
                    end else if (a_cmp_s == 8'h00) begin
                        result_d  = 32'h0000_0000;
                        match_d   = idx_q;
                        decided_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and result registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_a_q    <= {CNT_W{1'b0}};
            cnt_b_q    <= {CNT_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            decided_q  <= 1'b0;
            result_q   <= 32'h0000_0000;
            match_q    <= {IDX_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            idx_q      <= idx_d;
            decided_q  <= decided_d;
            result_q   <= result_d;
            match_q    <= match_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents past the count are never read, so no reset needed.
    always_ff @(posedge clock) begin
        if (wr_a_s) begin
            mem_a_q[cnt_a_q[PTR_W-1:0]] <= data_in;
        end
        if (wr_b_s) begin
            mem_b_q[cnt_b_q[PTR_W-1:0]] <= data_in;
        end
    end

    assign result      = result_q;
    assign match_index = {{(16-IDX_W){1'b0}}, match_q};
    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q == ST_COMPARE);
    assign fifo_a_full = (cnt_a_q == CNT_FULL);
    assign fifo_b_full = (cnt_b_q == CNT_FULL);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_strcmp_core.sv
// Scoreboard bench for strcmp_core: each go pushes its expected result,
// index and latency; a negedge monitor pops on every rising done.
module tb_strcmp_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic        fifo_write = 1'b0;
    logic        fifo_select = 1'b0;
    logic        go = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] result;
    logic [15:0] match_index;
    logic        done, busy, fifo_a_full, fifo_b_full, overflow;

    typedef struct {
        logic [31:0] res;
        logic [15:0] idx;
        int          lat;
        int          go_edge;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   edge_cnt = 0;
    logic done_prev = 1'b0;

    strcmp_core dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .fifo_write  (fifo_write),
        .fifo_select (fifo_select),
        .go          (go),
        .clear       (clear),
        .result      (result),
        .match_index (match_index),
        .done        (done),
        .busy        (busy),
        .fifo_a_full (fifo_a_full),
        .fifo_b_full (fifo_b_full),
        .overflow    (overflow)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of done must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("match_index", {16'h0, match_index}, {16'h0, e.idx});
                    chk("latency", edge_cnt - e.go_edge, e.lat);
                end
            end
            done_prev = done;
        end
    end

    task automatic wr(input logic sel, input logic [31:0] d);
        @(negedge clock);
        fifo_write = 1'b1; fifo_select = sel; data_in = d;
        @(posedge clock); #1;
        fifo_write = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    task automatic start(input logic [31:0] r, input logic [15:0] i, input int lat);
        exp_t e;
        @(negedge clock);
        go = 1'b1;
        e.res = r; e.idx = i; e.lat = lat; e.go_edge = edge_cnt + 1;
        sb_q.push_back(e);
        @(posedge clock); #1;
        go = 1'b0;
    endtask

    task automatic wr_go(input logic sel, input logic [31:0] d,
                         input logic [31:0] r, input logic [15:0] i, input int lat);
        exp_t e;
        @(negedge clock);
        fifo_write = 1'b1; fifo_select = sel; data_in = d; go = 1'b1;
        e.res = r; e.idx = i; e.lat = lat; e.go_edge = edge_cnt + 1;
        sb_q.push_back(e);
        @(posedge clock); #1;
        fifo_write = 1'b0; go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 200 cycles", name);
        end
    endtask

    initial begin
        bit saw_done;
        // Reset and reset-state checks
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_result", result, 32'h0);
        chk("rst_match", {16'h0, match_index}, 32'h0);
        chk("rst_flags", {26'h0, done, busy, fifo_a_full, fifo_b_full, overflow}, 32'h0);

        // Equal strings "abc" == "abc"
        wr(1'b0, 32'h0063_6261);
        wr(1'b1, 32'h0063_6261);
        start(32'h0, 16'd3, 5);
        wait_done("eq");
        chk("eq_busy_low", {31'h0, busy}, 32'h0);

        // "abc" vs "abd", then re-run from DONE
        pulse_clear();
        wr(1'b0, 32'h0063_6261);
        wr(1'b1, 32'h0064_6261);
        start(32'hFFFF_FFFF, 16'd2, 4);
        wait_done("lt");
        start(32'hFFFF_FFFF, 16'd2, 4);
        chk("rerun_done_drop", {31'h0, done}, 32'h0);
        wait_done("rerun");

        // "abcd" vs "abc"
        pulse_clear();
        wr(1'b0, 32'h6463_6261);
        wr(1'b0, 32'h0000_0000);
        wr(1'b1, 32'h0063_6261);
        start(32'h0000_0064, 16'd3, 5);
        wait_done("gt");

        // Reset two cycles into COMPARE aborts: no done, outputs cleared
        pulse_clear();
        wr(1'b0, 32'h0063_6261);
        wr(1'b1, 32'h0063_6261);
        @(negedge clock);
        go = 1'b1;
        @(posedge clock); #1;
        go = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'h0, saw_done}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_match", {16'h0, match_index}, 32'h0);
        chk("abort_flags", {26'h0, done, busy, fifo_a_full, fifo_b_full, overflow}, 32'h0);

        // Empty vs empty, then a write in DONE is dropped and flags overflow
        start(32'h0, 16'd0, 2);
        wait_done("empty");
        wr(1'b0, 32'h0000_0041);
        chk("ovf_in_done", {31'h0, overflow}, 32'h1);
        pulse_clear();
        @(negedge clock);
        chk("clear_ovf", {31'h0, overflow}, 32'h0);

        // clear and go together: clear wins, comparator stays idle
        @(negedge clock);
        clear = 1'b1; go = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; go = 1'b0;
        repeat (4) @(negedge clock);
        chk("clear_wins", {30'h0, busy, done}, 32'h0);

        // Fill A, 17th write dropped; fill B; no decision until index 64
        for (int n = 0; n < 16; n++) wr(1'b0, 32'h6161_6161);
        @(negedge clock);
        chk("a_full", {30'h0, fifo_a_full, overflow}, 32'h2);
        wr(1'b0, 32'h1234_5678);
        @(negedge clock);
        chk("a_overflow", {30'h0, fifo_a_full, overflow}, 32'h3);
        for (int n = 0; n < 16; n++) wr(1'b1, 32'h6161_6161);
        @(negedge clock);
        chk("b_full", {31'h0, fifo_b_full}, 32'h1);
        start(32'h0, 16'd64, 66);
        wait_done("maxlen");
        pulse_clear();
        @(negedge clock);
        chk("clear_all", {29'h0, fifo_a_full, fifo_b_full, overflow}, 32'h0);

        // "ABC" vs "abc": case-sensitive unless folding is compiled in
        wr(1'b0, 32'h0043_4241);
        wr(1'b1, 32'h0063_6261);
`ifdef STRCMP_CASE_FOLD_EN
        start(32'h0, 16'd3, 5);
`else
        start(32'hFFFF_FFE0, 16'd0, 2);
`endif
        wait_done("case");

        // Write and go in the same cycle: the word takes part in the compare
        pulse_clear();
        wr(1'b1, 32'h0000_6261);
        wr_go(1'b0, 32'h0000_6261, 32'h0, 16'd2, 4);
        wait_done("wr_go");

        repeat (3) @(negedge clock);
        chk("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
